// File: rtl/hyper_mem_responder.sv
// ----------------------------------------------------------------------------
// hyper_mem_responder
//
// HyperBus memory-device responder seen from the controller's SDR pad view:
// one 16-bit word per CK cycle (dq[15:8] = first DDR edge, dq[7:0] = second).
// Decodes the 48-bit command/address, waits the configured initial latency,
// then serves linear or wrapped bursts from an internal word memory. Also
// holds the read-only ID0 register and the read/write CR0 register.
//
// Ports:
//   sys_clk_i        clock, one bus word per cycle
//   rst_i            asynchronous active-high reset
//   hyper_cs_ni      chip select, active low
//   hyper_dq_i       CA / write data from the controller
//   hyper_dq_oe_i    controller drives dq (qualifies CA and write words)
//   hyper_rwds_i     write byte mask (bit1 -> dq[15:8], bit0 -> dq[7:0])
//   hyper_dq_o       read data
//   hyper_dq_oe_o    responder drives dq
//   hyper_rwds_o     latency indication during CA/LAT, 2'b10 during read data
//   hyper_rwds_oe_o  responder drives rwds
//   evt_eot_o        one-cycle pulse after a transaction that moved data
// ----------------------------------------------------------------------------
module hyper_mem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter logic [15:0] ID0_VAL = 16'h0C81,
  parameter logic [15:0] CR0_RST = 16'h8F1F
) (
  input  logic        sys_clk_i,
  input  logic        rst_i,
  input  logic        hyper_cs_ni,
  input  logic [15:0] hyper_dq_i,
  input  logic        hyper_dq_oe_i,
  input  logic [1:0]  hyper_rwds_i,
  output logic [15:0] hyper_dq_o,
  output logic        hyper_dq_oe_o,
  output logic [1:0]  hyper_rwds_o,
  output logic        hyper_rwds_oe_o,
  output logic        evt_eot_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE, CA0, CA1, CA2, LAT, WDATA, RDATA, REGW
  } state_t;

  state_t        state_reg;
  logic [15:0]   ca0_reg;
  logic [15:0]   ca1_reg;
  logic [AW-1:0] addr_reg;
  logic          is_read_reg;
  logic          is_reg_reg;
  logic          is_linear_reg;
  logic          regw_cr0_reg;
  logic          regw_done_reg;
  logic [5:0]    lat_cnt_reg;
  logic [15:0]   cr0_reg;
  logic [15:0]   reg_rdata_reg;
  logic          moved_reg;
  logic          dq_oe_reg;
  logic          rwds_oe_reg;
  logic [1:0]    rwds_reg;
  logic          data_valid_reg;
  logic          eot_reg;

  // --------------------------------------------------------------------------
  // CA decode, evaluated while the third CA word is on the bus.
  // --------------------------------------------------------------------------
  logic [AW-1:0] ca_addr;
  logic          sel_id0;
  logic          sel_cr0;

  // Word address = {CA[44:16], CA[2:0]} truncated to the memory depth.
  assign ca_addr = AW'({ca0_reg[12:0], ca1_reg, hyper_dq_i[2:0]});

  // Register space is selected by the full CA address: upper bits zero and
  // the low CA word naming the register (0x0000 = ID0, 0x0800 = CR0).
  assign sel_id0 = ({ca0_reg[12:0], ca1_reg} == 29'd0) && (hyper_dq_i == 16'h0000);
  assign sel_cr0 = ({ca0_reg[12:0], ca1_reg} == 29'd0) && (hyper_dq_i == 16'h0800);

  // Initial latency: CR0[7:4] cycles (0 means 16), doubled in fixed-2x mode.
  logic [4:0] lat_base;
  logic [5:0] lat_n;

  assign lat_base = (cr0_reg[7:4] == 4'd0) ? 5'd16 : {1'b0, cr0_reg[7:4]};
  assign lat_n    = cr0_reg[3] ? {lat_base, 1'b0} : {1'b0, lat_base};

  // --------------------------------------------------------------------------
  // Burst address increment: linear wraps at DEPTH, wrapped bursts only roll
  // the low bits selected by CR0[1:0] and keep the upper bits.
  // --------------------------------------------------------------------------
  logic [AW-1:0] wrap_mask;
  logic [AW-1:0] addr_inc;

  always_comb begin
    wrap_mask = AW'(63);
    unique case (cr0_reg[1:0])
      2'b00: wrap_mask = AW'(63);
      2'b01: wrap_mask = AW'(31);
      2'b10: wrap_mask = AW'(7);
      2'b11: wrap_mask = AW'(15);
    endcase
    if (is_linear_reg) begin
      addr_inc = addr_reg + AW'(1);
    end else begin
      addr_inc = (addr_reg & ~wrap_mask) | ((addr_reg + AW'(1)) & wrap_mask);
    end
  end

  // --------------------------------------------------------------------------
  // Word memory, one byte lane per array so byte enables map onto plain
  // single-port write / registered-read RAMs. The read address runs one
  // cycle ahead of the data phase so the registered output lines up.
  // --------------------------------------------------------------------------
  logic          mem_we;
  logic [1:0]    mem_be;
  logic [AW-1:0] rd_addr;
  logic [15:0]   mem_rdata;

  assign mem_we  = (state_reg == WDATA) && !hyper_cs_ni && hyper_dq_oe_i;
  assign mem_be  = ~hyper_rwds_i;
  assign rd_addr = (state_reg == RDATA) ? addr_inc : addr_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_rdata_reg;

      always_ff @(posedge sys_clk_i) begin
        if (mem_we && mem_be[gi]) begin
          lane_mem[addr_reg] <= hyper_dq_i[gi*8 +: 8];
        end
        lane_rdata_reg <= lane_mem[rd_addr];
      end

      assign mem_rdata[gi*8 +: 8] = lane_rdata_reg;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Transaction state machine with registered bus outputs.
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      ca0_reg        <= '0;
      ca1_reg        <= '0;
      addr_reg       <= '0;
      is_read_reg    <= 1'b0;
      is_reg_reg     <= 1'b0;
      is_linear_reg  <= 1'b0;
      regw_cr0_reg   <= 1'b0;
      regw_done_reg  <= 1'b0;
      lat_cnt_reg    <= '0;
      cr0_reg        <= CR0_RST;
      reg_rdata_reg  <= '0;
      moved_reg      <= 1'b0;
      dq_oe_reg      <= 1'b0;
      rwds_oe_reg    <= 1'b0;
      rwds_reg       <= 2'b00;
      data_valid_reg <= 1'b0;
      eot_reg        <= 1'b0;
    end else begin
      eot_reg <= 1'b0;
      if (hyper_cs_ni) begin
        // Deselect ends or aborts whatever is in flight.
        state_reg      <= IDLE;
        dq_oe_reg      <= 1'b0;
        rwds_oe_reg    <= 1'b0;
        rwds_reg       <= 2'b00;
        data_valid_reg <= 1'b0;
        regw_done_reg  <= 1'b0;
        moved_reg      <= 1'b0;
        eot_reg        <= moved_reg && (state_reg != IDLE);
      end else begin
        unique case (state_reg)
          IDLE: begin
            moved_reg     <= 1'b0;
            regw_done_reg <= 1'b0;
            rwds_oe_reg   <= 1'b1;
            rwds_reg      <= {2{cr0_reg[3]}};
            // Accept word0 already in the select cycle if it is present.
            if (hyper_dq_oe_i) begin
              ca0_reg   <= hyper_dq_i;
              state_reg <= CA1;
            end else begin
              state_reg <= CA0;
            end
          end
          CA0: begin
            if (hyper_dq_oe_i) begin
              ca0_reg   <= hyper_dq_i;
              state_reg <= CA1;
            end
          end
          CA1: begin
            if (hyper_dq_oe_i) begin
              ca1_reg   <= hyper_dq_i;
              state_reg <= CA2;
            end
          end
          CA2: begin
            if (hyper_dq_oe_i) begin
              is_read_reg   <= ca0_reg[15];
              is_reg_reg    <= ca0_reg[14];
              is_linear_reg <= ca0_reg[13];
              addr_reg      <= ca_addr;
              regw_cr0_reg  <= sel_cr0;
              reg_rdata_reg <= sel_id0 ? ID0_VAL : (sel_cr0 ? cr0_reg : 16'h0000);
              if (ca0_reg[14] && !ca0_reg[15]) begin
                // Register writes take data immediately, no latency.
                state_reg   <= REGW;
                rwds_oe_reg <= 1'b0;
                rwds_reg    <= 2'b00;
              end else begin
                state_reg   <= LAT;
                lat_cnt_reg <= lat_n - 6'd1;
              end
            end
          end
          LAT: begin
            if (lat_cnt_reg == 6'd0) begin
              if (is_read_reg) begin
                state_reg      <= RDATA;
                dq_oe_reg      <= 1'b1;
                rwds_reg       <= 2'b10;
                data_valid_reg <= 1'b1;
              end else begin
                // Release rwds so the controller can drive its byte mask.
                state_reg   <= WDATA;
                rwds_oe_reg <= 1'b0;
                rwds_reg    <= 2'b00;
              end
            end else begin
              lat_cnt_reg <= lat_cnt_reg - 6'd1;
            end
          end
          WDATA: begin
            // dq_oe_i low is a stall: nothing written, address held.
            if (hyper_dq_oe_i) begin
              addr_reg  <= addr_inc;
              moved_reg <= 1'b1;
            end
          end
          RDATA: begin
            addr_reg  <= addr_inc;
            moved_reg <= 1'b1;
          end
          REGW: begin
            if (hyper_dq_oe_i && !regw_done_reg) begin
              regw_done_reg <= 1'b1;
              moved_reg     <= 1'b1;
              if (regw_cr0_reg) begin
                cr0_reg <= hyper_dq_i;
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  // Output enables drop in the very cycle chip select is released.
  assign hyper_dq_oe_o   = dq_oe_reg & ~hyper_cs_ni;
  assign hyper_rwds_oe_o = rwds_oe_reg & ~hyper_cs_ni;
  assign hyper_rwds_o    = rwds_reg;
  assign hyper_dq_o      = data_valid_reg ? (is_reg_reg ? reg_rdata_reg : mem_rdata) : 16'h0000;
  assign evt_eot_o       = eot_reg;

endmodule
